// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: runs TLBP/TLBR/TLBWI/TLBWR one at a time on the shared TLB.
// Define TLB_FLUSH_EN to add a whole-array flush sequence (flush_req/flush_busy).
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
`ifdef TLB_FLUSH_EN
  input  logic            flush_req,
  output logic            flush_busy,
`endif
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  output logic            op_done,
  input  logic [89:0]     cp0_entry,
  input  logic [IDXW-1:0] cp0_index,
  input  logic [IDXW-1:0] cp0_wired,
  input  logic            cp0_wired_we,
  output logic [IDXW-1:0] random,
  output logic [18:0]     tlb_s_vpn2,
  output logic [7:0]      tlb_s_asid,
  input  logic            tlb_s_found,
  input  logic [IDXW-1:0] tlb_s_index,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [89:0]     tlb_r_entry,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [89:0]     tlb_w_entry,
  output logic            idx_we,
  output logic            idx_p,
  output logic [IDXW-1:0] idx_val,
  output logic            ent_we,
  output logic [89:0]     ent_val
);

  localparam logic [1:0] OP_P  = 2'b00;
  localparam logic [1:0] OP_R  = 2'b01;
  localparam logic [1:0] OP_WR = 2'b11;

  localparam logic [IDXW-1:0] RMAX = IDXW'(TLBNUM - 1);

`ifdef TLB_FLUSH_EN
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_RESP, S_FLUSH
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_RESP
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [89:0]     entry_q, entry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            found_q, found_d;
  logic [IDXW-1:0] hit_q, hit_d;
  logic [89:0]     rent_q, rent_d;
  logic [IDXW-1:0] random_q, random_d;

`ifdef TLB_FLUSH_EN
  logic [IDXW-1:0] fcnt_q, fcnt_d;
  logic            fl_q, fl_d;
  logic            in_flush;
`endif

  logic is_p, is_r, is_w;
  logic resp_op;

  assign is_p = (op_q == OP_P);
  assign is_r = (op_q == OP_R);
  assign is_w = op_q[1];

  // Random: reload on Wired write, pin when Wired covers everything,
  // wrap at Wired (or below it), otherwise count down every cycle.
  always_comb begin
    random_d = random_q - 1'b1;
    if (cp0_wired_we) begin
      random_d = RMAX;
    end else if (cp0_wired >= RMAX) begin
      random_d = RMAX;
    end else if (random_q <= cp0_wired) begin
      random_d = RMAX;
    end
  end

  // Next-state and latch control for the op sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    entry_d = entry_q;
    idx_d   = idx_q;
    found_d = found_q;
    hit_d   = hit_q;
    rent_d  = rent_q;
`ifdef TLB_FLUSH_EN
    fcnt_d  = fcnt_q;
    fl_d    = fl_q;
`endif
    unique case (state_q)
      S_IDLE: begin
`ifdef TLB_FLUSH_EN
        if (flush_req) begin
          fcnt_d  = '0;
          fl_d    = 1'b1;
          state_d = S_FLUSH;
        end else
`endif
        if (op_valid) begin
          op_d    = op_code;
          entry_d = cp0_entry;
          idx_d   = (op_code == OP_WR) ? random_q : cp0_index;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_p) begin
          found_d = tlb_s_found;
          hit_d   = tlb_s_index;
        end
        if (is_r) begin
          rent_d = tlb_r_entry;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
`ifdef TLB_FLUSH_EN
        fl_d    = 1'b0;
`endif
        state_d = S_IDLE;
      end
`ifdef TLB_FLUSH_EN
      S_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == RMAX) begin
          state_d = S_RESP;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched operands, results and Random.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      entry_q  <= '0;
      idx_q    <= '0;
      found_q  <= 1'b0;
      hit_q    <= '0;
      rent_q   <= '0;
      random_q <= RMAX;
`ifdef TLB_FLUSH_EN
      fcnt_q   <= '0;
      fl_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      entry_q  <= entry_d;
      idx_q    <= idx_d;
      found_q  <= found_d;
      hit_q    <= hit_d;
      rent_q   <= rent_d;
      random_q <= random_d;
`ifdef TLB_FLUSH_EN
      fcnt_q   <= fcnt_d;
      fl_q     <= fl_d;
`endif
    end
  end

  // Outputs; pulses are masked by reset so an abort never writes or completes.
  always_comb begin
    op_ready    = (state_q == S_IDLE);
    op_done     = (state_q == S_RESP) && !reset;
    resp_op     = op_done;
    tlb_we      = (state_q == S_EXEC) && is_w && !reset;
    tlb_w_index = idx_q;
    tlb_w_entry = entry_q;
`ifdef TLB_FLUSH_EN
    in_flush    = (state_q == S_FLUSH);
    flush_busy  = in_flush;
    resp_op     = op_done && !fl_q;
    if (in_flush) begin
      tlb_we      = !reset;
      tlb_w_index = fcnt_q;
      tlb_w_entry = '0;
    end
`endif
    tlb_s_vpn2  = entry_q[77:59];
    tlb_s_asid  = entry_q[58:51];
    tlb_r_index = idx_q;
    idx_we      = resp_op && is_p;
    idx_p       = ~found_q;
    idx_val     = found_q ? hit_q : '0;
    ent_we      = resp_op && is_r;
    ent_val     = rent_q;
    random      = random_q;
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequencer for the shared TLB array. It executes one TLB instruction at a time: TLBP (probe), TLBR (read), TLBWI (write indexed) and TLBWR (write random).
- Sits between the WB-stage CP0 logic and the TLB's search-port-2, read and write ports.
- Owns the Random register used by TLBWR.
- Returns probe and read results to CP0 as one-cycle update pulses.

Parameters:
- TLBNUM, 16, number of TLB entries; power of two, 4..32.
- IDXW, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  instruction request
- op_ready  out  1  controller can accept a request
- op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_done  out  1  one-cycle completion pulse
- cp0_entry  in  90  packed EntryHi/PageMask/EntryLo0/EntryLo1 (ENTRY layout below)
- cp0_index  in  IDXW  CP0 Index.index field
- cp0_wired  in  IDXW  CP0 Wired value
- cp0_wired_we  in  1  Wired is being written this cycle
- random  out  IDXW  current Random register
- tlb_s_vpn2  out  19  search-port vpn2
- tlb_s_asid  out  8  search-port asid
- tlb_s_found  in  1  search hit
- tlb_s_index  in  IDXW  search hit index
- tlb_r_index  out  IDXW  read-port index
- tlb_r_entry  in  90  read-port entry, ENTRY layout
- tlb_we  out  1  write enable
- tlb_w_index  out  IDXW  write index
- tlb_w_entry  out  90  write data, ENTRY layout
- idx_we  out  1  CP0 Index update pulse (TLBP)
- idx_p  out  1  Index.P value; 1 means miss
- idx_val  out  IDXW  Index.index value
- ent_we  out  1  CP0 EntryHi/Lo/PageMask update pulse (TLBR)
- ent_val  out  90  entry value for CP0

Behaviour:
- ENTRY layout, MSB to LSB: mask[11:0], vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1 (90 bits).
- States: IDLE, EXEC, RESP; plus FLUSH when the optional feature is compiled in.
- IDLE:
  - op_ready=1.
  - On op_valid: latch op_code and cp0_entry.
  - Latch index: cp0_index for TLBR/TLBWI; random for TLBWR.
  - Go to EXEC.
- EXEC (exactly one cycle), by opcode:
  - TLBP: drive tlb_s_vpn2/asid from the latched entry; register tlb_s_found and tlb_s_index.
  - TLBR: drive tlb_r_index; register tlb_r_entry.
  - TLBWI/TLBWR: tlb_we=1 with the latched index and entry.
  - Go to RESP.
- RESP (one cycle):
  - op_done=1.
  - TLBP: idx_we=1, idx_p=~found, idx_val=found ? hit index : 0.
  - TLBR: ent_we=1, ent_val=registered read entry.
  - Go to IDLE.
- Timing:
  - op_ready=0 in EXEC and RESP.
  - Latency from accept to op_done is 2 cycles, so throughput is 1 op per 3 cycles.
- Outputs outside their asserting states:
  - tlb_we, op_done, idx_we and ent_we are 0.
  - Search, read and write data outputs hold the last latched values.
- Random register:
  - Reset value TLBNUM-1.
  - Decrements every cycle.
  - When random==cp0_wired it wraps to TLBNUM-1 next cycle.
  - If cp0_wired>=TLBNUM-1, random stays at TLBNUM-1.
  - cp0_wired_we forces random to TLBNUM-1 next cycle; this has priority over decrement.
  - Random keeps counting during every state.
- Reset: state=IDLE; all pulses 0; latched index, entry and results 0; random=TLBNUM-1.
- Reset mid-operation aborts immediately: no write, no op_done.
- op_valid while not ready: ignored; requester must hold it until op_ready.

Optional Feature:
- Macro TLB_FLUSH_EN.
- With the macro defined:
  - Extra ports flush_req (in, 1) and flush_busy (out, 1).
  - In IDLE, flush_req has priority over op_valid and moves to FLUSH.
  - FLUSH drives tlb_we=1 with tlb_w_entry=0, using a counter from 0 to TLBNUM-1, one entry per cycle. This takes TLBNUM cycles.
  - Then one-cycle op_done, then IDLE.
  - flush_busy=1 and op_ready=0 throughout FLUSH.
  - Reset aborts the flush.
- Without the macro: no ports, no FLUSH state, no counter logic.

Test Plan:
- Reset, then read random at cycles 1..3: values 15, 14, 13 (TLBNUM=16, wired=0). At the cycle where random=0, the next value is 15.
- Wired: cp0_wired=4 with pulse on cp0_wired_we → random=15, counts down to 4, then wraps to 15; value never below 4.
- TLBWI: index=5, entry vpn2=0x12345 → tlb_we=1 with w_index=5 exactly 1 cycle after accept; op_done 2 cycles after accept; op_ready low for 2 cycles.
- TLBP: entry matches slot 5 → idx_we=1, idx_p=0, idx_val=5. TLBP with unmatched vpn2 → idx_p=1, idx_val=0.
- TLBR: index=5 after the TLBWI above → ent_we=1 and ent_val equals the written entry, with mask applied by the TLB. Then TLBWR: tlb_w_index equals the random value sampled at the accept cycle. Then assert reset during EXEC → no tlb_we pulse, no op_done, state IDLE.
- TLB_FLUSH_EN only: flush_req and op_valid asserted together → 16 consecutive tlb_we pulses at indices 0..15 with zero data, then op_done. The op is accepted only after flush_busy falls.
